serial_adder: RTL and testbench

Parametrised bit-serial ripple adder; successor to the single-bit combinational full adder.
- Adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first, through a single registered full-adder cell.
- Uses a start/busy/done handshake.
- Sits behind the Tiny Tapeout user-project wrapper. ui_in carries the operands; uo_out carries the result and status.

---
 rtl/serial_adder.sv | 164 ++++++++++++++++
 tb/tb_serial_adder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one registered full-adder cell, LSB first, start/busy/done handshake.
// Optional subtract mode and signed overflow flag enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               s_c;
    logic               maj_c;
`ifdef SERIAL_ADDER_SUB_EN
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               ovf_q, ovf_d;
`endif

    assign s_c   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign maj_c = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);

    // Next-state and datapath: everything holds unless ena is high.
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        busy_d   = busy_q;
        done_d   = done_q;
`ifdef SERIAL_ADDER_SUB_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        if (ena) begin
            case (state_q)
                IDLE, DONE: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    if (start) begin
                        state_d = SHIFT;
                        busy_d  = 1'b1;
                        a_sr_d  = a;
                        b_sr_d  = b;
                        carry_d = cin;
                        cnt_d   = '0;
`ifdef SERIAL_ADDER_SUB_EN
                        if (sub) begin
                            b_sr_d  = ~b;
                            carry_d = 1'b1;
                        end
                        a_msb_d = a[WIDTH-1];
                        b_msb_d = b_sr_d[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    carry_d  = maj_c;
                    sum_sr_d = {s_c, sum_sr_q[WIDTH-1:1]};
                    a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                    b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        // Final bit: publish the result; s_c is the result MSB.
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        sum_d   = sum_sr_d;
                        cout_d  = maj_c;
`ifdef SERIAL_ADDER_SUB_EN
                        ovf_d   = (a_msb_q == b_msb_q) && (s_c != a_msb_q);
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef SERIAL_ADDER_SUB_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign ovf        = 1'b0;
`endif

    assign sum  = sum_q;
    assign cout = cout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomised self-checking bench for serial_adder against an arithmetic reference model.
module tb_serial_adder;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ena_i;
    logic         start_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         cin_i;
    logic         sub_i;
    logic [W-1:0] sum_o;
    logic         cout_o;
    logic         ovf_o;
    logic         busy_o;
    logic         done_o;

    int           passed = 0;
    int           total  = 0;
    logic [W-1:0] prev_sum = '0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena_i),
        .start (start_i),
        .a     (a_i),
        .b     (b_i),
        .cin   (cin_i),
        .sub   (sub_i),
        .sum   (sum_o),
        .cout  (cout_o),
        .ovf   (ovf_o),
        .busy  (busy_o),
        .done  (done_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        else
            passed++;
    endtask

    // Called at a negedge; launches one operation and returns at the negedge where done is seen.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input logic ts, input int stall_at, input int stall_len, input bit inj);
        logic [W:0]   full;
        logic [W-1:0] beff;
        logic         eovf;
        int           cyc;
        int           busy_n;
        int           stalled;
        bit           seen;
        beff = tb_v;
        full = {1'b0, ta} + {1'b0, tb_v} + (W+1)'(tc);
`ifdef SERIAL_ADDER_SUB_EN
        if (ts) begin
            beff = ~tb_v;
            full = {1'b0, ta} + {1'b0, beff} + (W+1)'(1);
        end
        eovf = (ta[W-1] == beff[W-1]) && (full[W-1] != ta[W-1]);
`else
        eovf = 1'b0;
`endif
        a_i = ta; b_i = tb_v; cin_i = tc; sub_i = ts; start_i = 1'b1; ena_i = 1'b1;
        cyc = 0; busy_n = 0; stalled = 0; seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start_i = 1'b0;
            if (inj && cyc == 2) begin
                start_i = 1'b1; a_i = W'(9); b_i = W'(9);
            end
            if (done_o) begin
                seen = 1'b1;
                check_eq("busy_in_done", 32'(busy_o), 0);
            end else begin
                if (busy_o) busy_n++;
                check_eq("sum_held", 32'(sum_o), 32'(prev_sum));
            end
            if (stall_len > 0 && cyc >= stall_at && stalled < stall_len) begin
                ena_i = 1'b0; stalled++;
            end else begin
                ena_i = 1'b1;
            end
        end
        check_eq("done_seen", 32'(seen), 1);
        check_eq("latency", 32'(cyc), 32'(W + 1 + stall_len));
        check_eq("busy_cycles", 32'(busy_n), 32'(W + stall_len));
        check_eq("sum", 32'(sum_o), 32'(full[W-1:0]));
        check_eq("cout", 32'(cout_o), 32'(full[W]));
        check_eq("ovf", 32'(ovf_o), 32'(eovf));
        prev_sum = full[W-1:0];
    endtask

    // One idle cycle after completion: done must have dropped and nothing restarted.
    task automatic idle_check();
        start_i = 1'b0;
        @(negedge clk);
        check_eq("done_one_cycle", 32'(done_o), 0);
        check_eq("idle_busy", 32'(busy_o), 0);
        check_eq("idle_sum_held", 32'(sum_o), 32'(prev_sum));
    endtask

    initial begin
        rst_n = 1'b0; ena_i = 1'b1; start_i = 1'b0;
        a_i = '0; b_i = '0; cin_i = 1'b0; sub_i = 1'b0;
        #12;
        check_eq("rst_sum", 32'(sum_o), 0);
        check_eq("rst_cout", 32'(cout_o), 0);
        check_eq("rst_ovf", 32'(ovf_o), 0);
        check_eq("rst_busy", 32'(busy_o), 0);
        check_eq("rst_done", 32'(done_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(W'(3), W'(5), 1'b0, 1'b0, 0, 0, 1'b0);
        idle_check();

        run_op(W'(15), W'(1), 1'b0, 1'b0, 0, 0, 1'b0);
        run_op(W'(7), W'(8), 1'b1, 1'b0, 0, 0, 1'b0);
        idle_check();

        run_op(W'(2), W'(2), 1'b0, 1'b0, 0, 0, 1'b1);
        idle_check();

        run_op(W'(6), W'(5), 1'b0, 1'b0, 2, 3, 1'b0);
        idle_check();

        // Reset in the middle of a shift discards everything immediately.
        a_i = W'(15); b_i = W'(15); cin_i = 1'b0; sub_i = 1'b0; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_sum", 32'(sum_o), 0);
        check_eq("midrst_cout", 32'(cout_o), 0);
        check_eq("midrst_busy", 32'(busy_o), 0);
        check_eq("midrst_done", 32'(done_o), 0);
        prev_sum = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(W'(1), W'(1), 1'b0, 1'b0, 0, 0, 1'b0);
        idle_check();

        run_op(W'(5), W'(7), 1'b0, 1'b1, 0, 0, 1'b0);
        idle_check();
        run_op(W'(7), W'(8), 1'b0, 1'b1, 0, 0, 1'b0);
        idle_check();

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            int           slen;
            ra   = W'($urandom);
            rb   = W'($urandom);
            slen = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_op(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(1, W - 1)), slen,
                   1'($urandom));
            if ($urandom_range(0, 1) == 0) idle_check();
        end

        idle_check();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
